// File: rtl/pulse_width_monitor_if.sv
// Measurement port of pulse_width_monitor: one completed run per valid/ready transfer.
// The monitor drives the master side, the consumer (checker/logger) drives the slave side.
interface pulse_width_monitor_if #(
    parameter int WIDTH_W = 16
) ();
    logic               width_valid;
    logic               width_ready;
    logic               width_level;
    logic [WIDTH_W-1:0] width_count;
    logic               width_sat;

    modport master (
        output width_valid,
        output width_level,
        output width_count,
        output width_sat,
        input  width_ready
    );

    modport slave (
        input  width_valid,
        input  width_level,
        input  width_count,
        input  width_sat,
        output width_ready
    );
endinterface

// File: rtl/pulse_width_monitor.sv
// Resynchronises an async line, measures every high/low run in clk cycles and publishes it on a
// valid/ready port; counts rising edges. Optional glitch filter: define PWM_GLITCH_FILTER_EN.
module pulse_width_monitor #(
    parameter int WIDTH_W    = 16,
    parameter int EDGE_W     = 8,
    parameter int FILTER_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  clear,
    pulse_width_monitor_if.master mon,
    output logic                  overrun,
    output logic [EDGE_W-1:0]     edge_count
);
    localparam logic [WIDTH_W-1:0] CNT_MAX = {WIDTH_W{1'b1}};

    logic               s1_r;
    logic               s2_r;
    logic               lvl_r;
    logic               primed_r;
    logic [WIDTH_W-1:0] cnt_r;
    logic               valid_r;
    logic               level_r;
    logic [WIDTH_W-1:0] count_r;
    logic               sat_r;
    logic               overrun_r;
    logic [EDGE_W-1:0]  edge_r;
    logic               change_s;
    logic               rise_s;

`ifdef PWM_GLITCH_FILTER_EN
    localparam int STAB_W = $clog2(FILTER_LEN + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);

    logic [STAB_W-1:0] stab_r;

    // Accept the new level on the cycle the disagreement would reach FILTER_LEN consecutive cycles
    always_comb begin
        change_s = 1'b0;
        if ((s2_r != lvl_r) && (stab_r == STAB_LAST)) begin
            change_s = 1'b1;
        end else begin
            change_s = 1'b0;
        end
    end

    // Stability counter: cycles the synchronised input has disagreed with the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_r <= {STAB_W{1'b0}};
        end else if ((s2_r == lvl_r) || change_s) begin
            stab_r <= {STAB_W{1'b0}};
        end else begin
            stab_r <= stab_r + STAB_W'(1);
        end
    end
`else
    // Without the filter the accepted level follows the synchroniser output directly
    always_comb begin
        change_s = 1'b0;
        if (s2_r != lvl_r) begin
            change_s = 1'b1;
        end else begin
            change_s = 1'b0;
        end
    end
`endif

    // The accepted level becomes s2 on a change, so a rising change is one where s2 is high
    always_comb begin
        rise_s = 1'b0;
        if (change_s && s2_r) begin
            rise_s = 1'b1;
        end else begin
            rise_s = 1'b0;
        end
    end

    // Two-flop synchroniser and accepted level; clear deliberately leaves these tracking din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r  <= 1'b0;
            s2_r  <= 1'b0;
            lvl_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
            if (change_s) begin
                lvl_r <= s2_r;
            end else begin
                lvl_r <= lvl_r;
            end
        end
    end

    // Run-length counter (saturating) and priming: the run in progress at reset/clear has no known start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {WIDTH_W{1'b0}};
            primed_r <= 1'b0;
        end else if (clear) begin
            cnt_r    <= {WIDTH_W{1'b0}};
            primed_r <= 1'b0;
        end else if (change_s) begin
            cnt_r    <= WIDTH_W'(1);
            primed_r <= 1'b1;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + WIDTH_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Publish completed runs, run the handshake, flag overwrites and count rising edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            level_r   <= 1'b0;
            count_r   <= {WIDTH_W{1'b0}};
            sat_r     <= 1'b0;
            overrun_r <= 1'b0;
            edge_r    <= {EDGE_W{1'b0}};
        end else if (clear) begin
            valid_r   <= 1'b0;
            level_r   <= 1'b0;
            count_r   <= {WIDTH_W{1'b0}};
            sat_r     <= 1'b0;
            overrun_r <= 1'b0;
            edge_r    <= {EDGE_W{1'b0}};
        end else begin
            if (change_s && primed_r) begin
                valid_r <= 1'b1;
                level_r <= lvl_r;
                count_r <= cnt_r;
                sat_r   <= (cnt_r == CNT_MAX);
                // A pending measurement the consumer never took is lost here
                if (valid_r && !mon.width_ready) begin
                    overrun_r <= 1'b1;
                end else begin
                    overrun_r <= overrun_r;
                end
            end else if (valid_r && mon.width_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if (rise_s) begin
                edge_r <= edge_r + EDGE_W'(1);
            end else begin
                edge_r <= edge_r;
            end
        end
    end

    assign mon.width_valid = valid_r;
    assign mon.width_level = level_r;
    assign mon.width_count = count_r;
    assign mon.width_sat   = sat_r;
    assign overrun         = overrun_r;
    assign edge_count      = edge_r;

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Directed bench for pulse_width_monitor: a 16-bit instance for the main scenarios and a
// 4-bit instance sharing the same input line for counter saturation.
module tb_pulse_width_monitor;
    localparam int FLEN = 3;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int LAT = 3 + FLEN - 1;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       din = 1'b0;
    logic       clear = 1'b0;
    logic       overrun;
    logic [7:0] edge_count;
    logic       overrun4;
    logic [7:0] edge_count4;
    int         tests = 0;
    int         fails = 0;

    pulse_width_monitor_if #(.WIDTH_W(16)) bus ();
    pulse_width_monitor_if #(.WIDTH_W(4))  bus4 ();

    pulse_width_monitor #(.WIDTH_W(16), .EDGE_W(8), .FILTER_LEN(FLEN)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .clear(clear),
        .mon(bus.master), .overrun(overrun), .edge_count(edge_count)
    );

    pulse_width_monitor #(.WIDTH_W(4), .EDGE_W(8), .FILTER_LEN(FLEN)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .clear(clear),
        .mon(bus4.master), .overrun(overrun4), .edge_count(edge_count4)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.width_valid !== 1'b0 || bus.width_level !== 1'b0 || bus.width_sat !== 1'b0) begin
            $display("FAIL reset_flags: valid=%b level=%b sat=%b required 0 0 0", bus.width_valid, bus.width_level, bus.width_sat);
            fails++;
        end
        tests++;
        if (bus.width_count !== 16'd0 || overrun !== 1'b0 || edge_count !== 8'd0) begin
            $display("FAIL reset_data: count=%0d overrun=%b edges=%0d required 0 0 0", bus.width_count, overrun, edge_count);
            fails++;
        end
        @(negedge clk) rst_n = 1'b1;
        cyc(2);
        din = 1'b1;
        cyc(LAT);
        tests++;
        if (bus.width_valid !== 1'b0) begin
            $display("FAIL first_run_unpublished: valid=%b required 0", bus.width_valid);
            fails++;
        end
        tests++;
        if (edge_count !== 8'd1) begin
            $display("FAIL first_edge: edges=%0d required 1", edge_count);
            fails++;
        end
        din = 1'b0;
        cyc(LAT);
    endtask

    task automatic test_width();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        din = 1'b1;
        cyc(5);
        din = 1'b0;
        cyc(LAT);
        tests++;
        if (bus.width_valid !== 1'b1 || bus.width_level !== 1'b1) begin
            $display("FAIL width_flags: valid=%b level=%b required 1 1", bus.width_valid, bus.width_level);
            fails++;
        end
        tests++;
        if (bus.width_count !== 16'd5 || bus.width_sat !== 1'b0) begin
            $display("FAIL width_count: count=%0d sat=%b required 5 0", bus.width_count, bus.width_sat);
            fails++;
        end
        tests++;
        if (edge_count !== 8'd1) begin
            $display("FAIL width_edges: edges=%0d required 1", edge_count);
            fails++;
        end
        bus.width_ready = 1'b1;
        cyc(1);
        bus.width_ready = 1'b0;
        tests++;
        if (bus.width_valid !== 1'b0) begin
            $display("FAIL width_accept: valid=%b required 0", bus.width_valid);
            fails++;
        end
    endtask

    task automatic test_backpressure();
        din = 1'b1;
        cyc(4);
        din = 1'b0;
        cyc(6);
        din = 1'b1;
        cyc(LAT);
        tests++;
        if (bus.width_valid !== 1'b1 || bus.width_level !== 1'b0 || bus.width_count !== 16'd6) begin
            $display("FAIL bp_data: valid=%b level=%b count=%0d required 1 0 6", bus.width_valid, bus.width_level, bus.width_count);
            fails++;
        end
        tests++;
        if (overrun !== 1'b1) begin
            $display("FAIL bp_overrun: overrun=%b required 1", overrun);
            fails++;
        end
        tests++;
        if (edge_count !== 8'd3) begin
            $display("FAIL bp_edges: edges=%0d required 3", edge_count);
            fails++;
        end
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        tests++;
        if (overrun !== 1'b0 || bus.width_valid !== 1'b0 || edge_count !== 8'd0) begin
            $display("FAIL clear: overrun=%b valid=%b edges=%0d required 0 0 0", overrun, bus.width_valid, edge_count);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        din = 1'b0;
        cyc(LAT);
        tests++;
        if (bus.width_valid !== 1'b0) begin
            $display("FAIL b2b_unprimed: valid=%b required 0", bus.width_valid);
            fails++;
        end
        din = 1'b1;
        cyc(LAT);
        tests++;
        if (bus.width_valid !== 1'b1 || bus.width_level !== 1'b0 || bus.width_count !== 16'(LAT)) begin
            $display("FAIL b2b_first: valid=%b level=%b count=%0d required 1 0 %0d", bus.width_valid, bus.width_level, bus.width_count, LAT);
            fails++;
        end
        cyc(1);
        din = 1'b0;
        cyc(LAT - 1);
        bus.width_ready = 1'b1;
        cyc(1);
        tests++;
        if (bus.width_valid !== 1'b1 || bus.width_level !== 1'b1 || bus.width_count !== 16'(LAT + 1)) begin
            $display("FAIL b2b_reload: valid=%b level=%b count=%0d required 1 1 %0d", bus.width_valid, bus.width_level, bus.width_count, LAT + 1);
            fails++;
        end
        tests++;
        if (overrun !== 1'b0) begin
            $display("FAIL b2b_overrun: overrun=%b required 0", overrun);
            fails++;
        end
        cyc(1);
        bus.width_ready = 1'b0;
        tests++;
        if (bus.width_valid !== 1'b0) begin
            $display("FAIL b2b_drain: valid=%b required 0", bus.width_valid);
            fails++;
        end
    endtask

    task automatic test_glitch();
        cyc(5);
        din = 1'b1;
        cyc(1);
        din = 1'b0;
        cyc(LAT + 5);
`ifdef PWM_GLITCH_FILTER_EN
        tests++;
        if (bus.width_valid !== 1'b0) begin
            $display("FAIL glitch_filtered: valid=%b required 0", bus.width_valid);
            fails++;
        end
        tests++;
        if (edge_count !== 8'd1) begin
            $display("FAIL glitch_edges: edges=%0d required 1", edge_count);
            fails++;
        end
`else
        tests++;
        if (bus.width_valid !== 1'b1 || bus.width_level !== 1'b1 || bus.width_count !== 16'd1) begin
            $display("FAIL glitch_width: valid=%b level=%b count=%0d required 1 1 1", bus.width_valid, bus.width_level, bus.width_count);
            fails++;
        end
        tests++;
        if (edge_count !== 8'd2) begin
            $display("FAIL glitch_edges: edges=%0d required 2", edge_count);
            fails++;
        end
`endif
    endtask

    task automatic test_saturation();
        bus.width_ready = 1'b1;
        cyc(1);
        bus.width_ready = 1'b0;
        din = 1'b1;
        cyc(20);
        din = 1'b0;
        cyc(LAT);
        tests++;
        if (bus4.width_valid !== 1'b1 || bus4.width_level !== 1'b1) begin
            $display("FAIL sat_flags: valid=%b level=%b required 1 1", bus4.width_valid, bus4.width_level);
            fails++;
        end
        tests++;
        if (bus4.width_count !== 4'd15 || bus4.width_sat !== 1'b1) begin
            $display("FAIL sat_count: count=%0d sat=%b required 15 1", bus4.width_count, bus4.width_sat);
            fails++;
        end
        tests++;
        if (bus.width_count !== 16'd20 || bus.width_sat !== 1'b0) begin
            $display("FAIL wide_no_sat: count=%0d sat=%b required 20 0", bus.width_count, bus.width_sat);
            fails++;
        end
    endtask

    task automatic test_mid_reset();
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.width_valid !== 1'b0 || bus.width_count !== 16'd0 || edge_count !== 8'd0 || overrun !== 1'b0) begin
            $display("FAIL mid_reset: valid=%b count=%0d edges=%0d overrun=%b required 0 0 0 0", bus.width_valid, bus.width_count, edge_count, overrun);
            fails++;
        end
        tests++;
        if (bus4.width_valid !== 1'b0 || bus4.width_sat !== 1'b0) begin
            $display("FAIL mid_reset_narrow: valid=%b sat=%b required 0 0", bus4.width_valid, bus4.width_sat);
            fails++;
        end
        @(negedge clk) rst_n = 1'b1;
        cyc(LAT + 2);
        tests++;
        if (bus.width_valid !== 1'b0 || edge_count !== 8'd0) begin
            $display("FAIL post_reset_idle: valid=%b edges=%0d required 0 0", bus.width_valid, edge_count);
            fails++;
        end
    endtask

    initial begin
        bus.width_ready  = 1'b0;
        bus4.width_ready = 1'b0;
        test_reset();
        test_width();
        test_backpressure();
        test_back_to_back();
        test_glitch();
        test_saturation();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
